piezo_decoder: RTL and testbench
================================

PIEZO_DECODER -- requirements
Module: piezo_decoder

Interface
REQ-001 Parameter: fastSim, default 1, selects period windows and silence timeout (1 = sim-scaled, 0 = real-time at 50 MHz).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 piezo  input  1  square-wave tone input from the piezo driver.
REQ-005 piezo_n  input  1  complement of piezo.
REQ-006 note  output  3  last classified note: NONE=0, G6=1, C7=2, E7=3, G7=4.
REQ-007 note_vld  output  1  one-cycle pulse when a completed note is reported on note/note_len.
REQ-008 note_len  output  12  number of full periods in the reported note, saturating at 4095.
REQ-009 tune  output  2  last recognised tune: NONE=0, CHARGE=1, BATT_LOW=2, TOO_FAST=3.
REQ-010 tune_vld  output  1  one-cycle pulse when a tune is recognised.
REQ-011 pol_err  output  1  sticky flag, set when piezo==piezo_n is sampled for 2 consecutive cycles.

Function
REQ-012 piezo SHALL pass through a 2-flop synchroniser; rising edge = synchronised 0->1 transition.
REQ-013 A 16-bit period counter SHALL increment every cycle, saturate at 0xFFFF, and reload to 1 on each rising edge after its value is captured.
REQ-014 Nominal periods (cycles): fastSim=0 -> G6 31889, C7 23891, E7 18962, G7 15945; fastSim=1 -> 498, 373, 296, 249.
REQ-015 A captured period SHALL classify as a note when within nominal +/- nominal/16 (integer divide); otherwise it classifies as NONE.
REQ-016 The first rising edge after reset or silence SHALL only start measurement; it produces no classification.
REQ-017 Consecutive periods of the same class SHALL extend the current note, incrementing note_len (saturating).
REQ-018 A class change, or silence, SHALL end the current note: note_vld pulses 1 cycle after the terminating edge/timeout, with note/note_len of the ended note; a new note then begins with length 1 (or none on silence).
REQ-019 Silence = no rising edge for 65535 cycles (fastSim=0) or 1023 cycles (fastSim=1); detected when the period counter reaches that value.
REQ-020 Notes of class NONE SHALL be reported with note=NONE and SHALL reset the tune matcher.
REQ-021 Tune matcher FSM states: T_IDLE, FWD1..FWD5, REV1..REV5; advances only on note_vld.
REQ-022 CHARGE sequence: G6 C7 E7 G7 E7 G7; BATT_LOW sequence: G7 E7 G7 E7 C7 G6; TOO_FAST: G6 C7 E7 followed by G6.
REQ-023 T_IDLE: G6 -> FWD1; G7 -> REV1; other -> T_IDLE.
REQ-024 FWDn/REVn: expected next note -> advance; final note of a sequence -> tune_vld pulse same cycle as transition, return T_IDLE.
REQ-025 FWD3 (after G6 C7 E7) receiving G6 SHALL pulse tune=TOO_FAST and go to FWD1.
REQ-026 Any unexpected note SHALL re-evaluate as from T_IDLE in the same cycle (G6 -> FWD1, G7 -> REV1, else T_IDLE).
REQ-027 tune holds its last value between pulses; note and note_len hold between pulses.
REQ-028 Simultaneous silence timeout and rising edge: the edge wins; timeout not reported.
REQ-029 pol_err SHALL be cleared only by reset.

Reset
REQ-030 While rst_n=0 at a clock edge: note=NONE, note_len=0, note_vld=0, tune=NONE, tune_vld=0, pol_err=0, FSM=T_IDLE, synchroniser=0, period counter=0, measurement disarmed.
REQ-031 Reset mid-note SHALL discard the note with no note_vld.

Structure
REQ-032 Package piezo_pkg SHALL hold note_t and tune_t enums and the nominal-period constants of REQ-014, shared with the piezo driver bench.
REQ-033 One sub-module, piezo_period_meas (synchroniser, edge detect, period counter, classifier, silence detect), SHALL be instantiated; matcher and reporting stay in the top.

Verification
REQ-034 fastSim=1, 40 periods of 498 cycles then silence -> one note_vld, note=G6, note_len=39, ~1023 cycles after last edge.
REQ-035 Driven CHARGE tune (G6,C7,E7 x N periods; G7 x 1.5N; E7 x 0.5N; G7 x 2N) -> six note_vld, one tune_vld with tune=CHARGE.
REQ-036 Reverse sequence G7 E7 G7 E7 C7 G6 -> tune_vld with tune=BATT_LOW.
REQ-037 G6 C7 E7 G6 C7 E7 G6 -> two tune_vld pulses, both TOO_FAST.
REQ-038 Period 400 cycles (between windows) -> note_vld with note=NONE, matcher in T_IDLE.
REQ-039 piezo=piezo_n=1 held 2 cycles -> pol_err=1, persisting until rst_n=0; rst_n low mid-note -> no note_vld.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared types and nominal tone periods for the piezo tone decoder and the piezo driver bench.
package piezo_pkg;

  typedef enum logic [2:0] {
    NOTE_NONE = 3'd0,
    NOTE_G6   = 3'd1,
    NOTE_C7   = 3'd2,
    NOTE_E7   = 3'd3,
    NOTE_G7   = 3'd4
  } note_t;

  typedef enum logic [1:0] {
    TUNE_NONE     = 2'd0,
    TUNE_CHARGE   = 2'd1,
    TUNE_BATT_LOW = 2'd2,
    TUNE_TOO_FAST = 2'd3
  } tune_t;

  typedef enum logic [3:0] {
    T_IDLE, FWD1, FWD2, FWD3, FWD4, FWD5, REV1, REV2, REV3, REV4, REV5
  } match_st_t;

  localparam logic [15:0] G6_PER_RT = 16'd31889;
  localparam logic [15:0] C7_PER_RT = 16'd23891;
  localparam logic [15:0] E7_PER_RT = 16'd18962;
  localparam logic [15:0] G7_PER_RT = 16'd15945;
  localparam logic [15:0] G6_PER_FS = 16'd498;
  localparam logic [15:0] C7_PER_FS = 16'd373;
  localparam logic [15:0] E7_PER_FS = 16'd296;
  localparam logic [15:0] G7_PER_FS = 16'd249;
  localparam logic [15:0] SIL_RT    = 16'hFFFF;
  localparam logic [15:0] SIL_FS    = 16'd1023;

  // Acceptance window is nominal +/- nominal/16, widened to 17 bits to avoid wrap.
  function automatic logic in_window(input logic [15:0] per, input logic [15:0] nom);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, nom} - {5'b0, nom[15:4]};
    hi = {1'b0, nom} + {5'b0, nom[15:4]};
    return ({1'b0, per} >= lo) && ({1'b0, per} <= hi);
  endfunction

endpackage

// File: rtl/piezo_period_meas.sv
// Synchronises the piezo tone, measures rising-edge periods, classifies each period
// and flags silence when no edge arrives within the timeout.
module piezo_period_meas import piezo_pkg::*; #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  piezo_i,
  output logic  per_vld_o,
  output note_t per_note_o,
  output logic  silence_o
);

  localparam logic [15:0] NOM_G6 = FAST_SIM ? G6_PER_FS : G6_PER_RT;
  localparam logic [15:0] NOM_C7 = FAST_SIM ? C7_PER_FS : C7_PER_RT;
  localparam logic [15:0] NOM_E7 = FAST_SIM ? E7_PER_FS : E7_PER_RT;
  localparam logic [15:0] NOM_G7 = FAST_SIM ? G7_PER_FS : G7_PER_RT;
  localparam logic [15:0] SIL    = FAST_SIM ? SIL_FS    : SIL_RT;

  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        rise;

  assign rise = sync1_q & ~sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= piezo_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // An edge coinciding with the timeout count takes priority over silence.
  always_comb begin
    cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    armed_d   = armed_q;
    per_vld_o = 1'b0;
    silence_o = 1'b0;
    if (rise) begin
      cnt_d     = 16'd1;
      armed_d   = 1'b1;
      per_vld_o = armed_q;
    end else if (armed_q && (cnt_q == SIL)) begin
      silence_o = 1'b1;
      armed_d   = 1'b0;
    end
  end

  always_comb begin
    per_note_o = NOTE_NONE;
    if (in_window(cnt_q, NOM_G6))      per_note_o = NOTE_G6;
    else if (in_window(cnt_q, NOM_C7)) per_note_o = NOTE_C7;
    else if (in_window(cnt_q, NOM_E7)) per_note_o = NOTE_E7;
    else if (in_window(cnt_q, NOM_G7)) per_note_o = NOTE_G7;
  end

endmodule

// File: rtl/piezo_decoder.sv
// Groups classified periods into notes, reports each finished note, matches note
// sequences against known tunes and flags a stuck/shorted piezo pair.
// State | meaning:  T_IDLE | no partial tune;  FWDn | first n notes of G6 C7 E7 G7 E7 G7 seen;
//                   REVn  | first n notes of G7 E7 G7 E7 C7 G6 seen
module piezo_decoder import piezo_pkg::*; #(
  parameter bit fastSim = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        piezo,
  input  logic        piezo_n,
  output logic [2:0]  note,
  output logic        note_vld,
  output logic [11:0] note_len,
  output logic [1:0]  tune,
  output logic        tune_vld,
  output logic        pol_err
);

  logic  per_vld, silence;
  note_t per_note;

  piezo_period_meas #(.FAST_SIM(fastSim)) u_meas (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .piezo_i    (piezo),
    .per_vld_o  (per_vld),
    .per_note_o (per_note),
    .silence_o  (silence)
  );

  note_t       cur_note_q, cur_note_d, note_q, note_d;
  logic [11:0] cur_len_q, cur_len_d, note_len_q, note_len_d;
  logic        active_q, active_d, note_vld_q, note_vld_d;
  match_st_t   st_q, st_d, restart;
  tune_t       tune_q, tune_d;
  logic        tune_vld_q, tune_vld_d;
  logic        eq_q, pol_err_q, pol_err_d, eq_now;

  assign eq_now    = (piezo == piezo_n);
  assign pol_err_d = pol_err_q | (eq_q & eq_now);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_note_q <= NOTE_NONE;
      cur_len_q  <= '0;
      active_q   <= 1'b0;
      note_q     <= NOTE_NONE;
      note_len_q <= '0;
      note_vld_q <= 1'b0;
      st_q       <= T_IDLE;
      tune_q     <= TUNE_NONE;
      tune_vld_q <= 1'b0;
      eq_q       <= 1'b0;
      pol_err_q  <= 1'b0;
    end else begin
      cur_note_q <= cur_note_d;
      cur_len_q  <= cur_len_d;
      active_q   <= active_d;
      note_q     <= note_d;
      note_len_q <= note_len_d;
      note_vld_q <= note_vld_d;
      st_q       <= st_d;
      tune_q     <= tune_d;
      tune_vld_q <= tune_vld_d;
      eq_q       <= eq_now;
      pol_err_q  <= pol_err_d;
    end
  end

  always_comb begin
    cur_note_d = cur_note_q;
    cur_len_d  = cur_len_q;
    active_d   = active_q;
    note_d     = note_q;
    note_len_d = note_len_q;
    note_vld_d = 1'b0;
    if (per_vld) begin
      if (active_q && (per_note == cur_note_q)) begin
        cur_len_d = (cur_len_q == 12'hFFF) ? cur_len_q : cur_len_q + 12'd1;
      end else begin
        if (active_q) begin
          note_vld_d = 1'b1;
          note_d     = cur_note_q;
          note_len_d = cur_len_q;
        end
        cur_note_d = per_note;
        cur_len_d  = 12'd1;
        active_d   = 1'b1;
      end
    end else if (silence && active_q) begin
      note_vld_d = 1'b1;
      note_d     = cur_note_q;
      note_len_d = cur_len_q;
      active_d   = 1'b0;
    end
  end

  // Any note that does not continue the current sequence is re-evaluated as a fresh start.
  always_comb begin
    st_d       = st_q;
    tune_d     = tune_q;
    tune_vld_d = 1'b0;
    restart    = (note_q == NOTE_G6) ? FWD1 : (note_q == NOTE_G7) ? REV1 : T_IDLE;
    if (note_vld_q) begin
      st_d = restart;
      case (st_q)
        FWD1: if (note_q == NOTE_C7) st_d = FWD2;
        FWD2: if (note_q == NOTE_E7) st_d = FWD3;
        FWD3: begin
          if (note_q == NOTE_G7) st_d = FWD4;
          else if (note_q == NOTE_G6) begin
            st_d       = FWD1;
            tune_d     = TUNE_TOO_FAST;
            tune_vld_d = 1'b1;
          end
        end
        FWD4: if (note_q == NOTE_E7) st_d = FWD5;
        FWD5: if (note_q == NOTE_G7) begin
          st_d       = T_IDLE;
          tune_d     = TUNE_CHARGE;
          tune_vld_d = 1'b1;
        end
        REV1: if (note_q == NOTE_E7) st_d = REV2;
        REV2: if (note_q == NOTE_G7) st_d = REV3;
        REV3: if (note_q == NOTE_E7) st_d = REV4;
        REV4: if (note_q == NOTE_C7) st_d = REV5;
        REV5: if (note_q == NOTE_G6) begin
          st_d       = T_IDLE;
          tune_d     = TUNE_BATT_LOW;
          tune_vld_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign note     = note_q;
  assign note_vld = note_vld_q;
  assign note_len = note_len_q;
  assign tune     = tune_q;
  assign tune_vld = tune_vld_q;
  assign pol_err  = pol_err_q;

endmodule

// File: tb/tb_piezo_decoder.sv
// Drives piezo tone sequences and checks reported notes and tunes against a
// sequence-level reference model (run-length notes, prefix matching for tunes).
module tb_piezo_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        piezo = 1'b0;
  logic        piezo_n = 1'b1;
  logic [2:0]  note;
  logic        note_vld;
  logic [11:0] note_len;
  logic [1:0]  tune;
  logic        tune_vld;
  logic        pol_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int nom[4]    = '{498, 373, 296, 249};
  int ch_seq[6] = '{1, 2, 3, 4, 3, 4};
  int bt_seq[6] = '{4, 3, 4, 3, 2, 1};

  int got_note[$], got_len[$], got_ncyc[$], got_tune[$];
  int exp_note[$], exp_len[$], exp_tune[$];
  int hist[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piezo_decoder #(.fastSim(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .piezo    (piezo),
    .piezo_n  (piezo_n),
    .note     (note),
    .note_vld (note_vld),
    .note_len (note_len),
    .tune     (tune),
    .tune_vld (tune_vld),
    .pol_err  (pol_err)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (note_vld) begin
        got_note.push_back(int'(note));
        got_len.push_back(int'(note_len));
        got_ncyc.push_back(cyc);
      end
      if (tune_vld) got_tune.push_back(int'(tune));
    end
  end

  // ---------------- reference model ----------------
  function automatic int classify(input int p);
    for (int k = 0; k < 4; k++)
      if (p >= nom[k] - nom[k] / 16 && p <= nom[k] + nom[k] / 16) return k + 1;
    return 0;
  endfunction

  function automatic bit is_prefix(input int which);
    if (hist.size() > 6) return 1'b0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i] != ((which == 0) ? ch_seq[i] : bt_seq[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_note(input int n, input int len);
    exp_note.push_back(n);
    exp_len.push_back((len > 4095) ? 4095 : len);
    hist.push_back(n);
    if (hist.size() == 4 && hist[0] == 1 && hist[1] == 2 && hist[2] == 3 && hist[3] == 1) begin
      exp_tune.push_back(3);
      hist.delete();
      hist.push_back(1);
    end else if (hist.size() == 6 && is_prefix(0)) begin
      exp_tune.push_back(1);
      hist.delete();
    end else if (hist.size() == 6 && is_prefix(1)) begin
      exp_tune.push_back(2);
      hist.delete();
    end else if (!is_prefix(0) && !is_prefix(1)) begin
      hist.delete();
      if (n == 1 || n == 4) hist.push_back(n);
    end
  endtask

  // Each interval is the spacing to the next rising edge; >= 1024 means silence first.
  task automatic model_seq(input int ivl[$]);
    int cur = -1;
    int len = 0;
    foreach (ivl[i]) begin
      if (ivl[i] >= 1024) begin
        if (cur >= 0) model_note(cur, len);
        cur = -1;
      end else if (cur == classify(ivl[i])) begin
        len++;
      end else begin
        if (cur >= 0) model_note(cur, len);
        cur = classify(ivl[i]);
        len = 1;
      end
    end
    if (cur >= 0) model_note(cur, len);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_p(input logic v);
    piezo   = v;
    piezo_n = ~v;
  endtask

  task automatic clear_q();
    got_note.delete(); got_len.delete(); got_ncyc.delete(); got_tune.delete();
    exp_note.delete(); exp_len.delete(); exp_tune.delete();
  endtask

  task automatic drive(input int ivl[$], input bit tail, output int last_edge);
    @(posedge clk); #1 set_p(1'b1);
    last_edge = cyc;
    foreach (ivl[i]) begin
      int h;
      h = ivl[i] / 2;
      repeat (h) @(posedge clk);
      #1 set_p(1'b0);
      repeat (ivl[i] - h) @(posedge clk);
      #1 set_p(1'b1);
      last_edge = cyc;
    end
    if (tail) begin
      repeat (4) @(posedge clk);
      #1 set_p(1'b0);
      repeat (1100) @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic int jit(input int n, input int d);
    return nom[n - 1] - d + int'($urandom_range(0, 2 * d));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_p(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (note !== 3'd0)      begin errors++; $display("FAIL reset_note: got %0d exp 0", note); end
    checks++; if (note_len !== 12'd0) begin errors++; $display("FAIL reset_note_len: got %0d exp 0", note_len); end
    checks++; if (note_vld !== 1'b0)  begin errors++; $display("FAIL reset_note_vld: got %b exp 0", note_vld); end
    checks++; if (tune !== 2'd0)      begin errors++; $display("FAIL reset_tune: got %0d exp 0", tune); end
    checks++; if (tune_vld !== 1'b0)  begin errors++; $display("FAIL reset_tune_vld: got %b exp 0", tune_vld); end
    checks++; if (pol_err !== 1'b0)   begin errors++; $display("FAIL reset_pol_err: got %b exp 0", pol_err); end
    hist.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single_note();
    int ivl[$];
    int le;
    clear_q();
    for (int i = 0; i < 39; i++) ivl.push_back(498);
    drive(ivl, 1'b1, le);
    checks++;
    if (got_note.size() !== 1) begin errors++; $display("FAIL single_count: got %0d exp 1", got_note.size()); end
    else begin
      checks++;
      if (got_note[0] !== 1 || got_len[0] !== 39) begin
        errors++; $display("FAIL single_note: got %0d/%0d exp 1/39", got_note[0], got_len[0]);
      end
      checks++;
      if (got_ncyc[0] - le < 1023 || got_ncyc[0] - le > 1027) begin
        errors++; $display("FAIL single_timeout: got %0d cycles exp ~1023", got_ncyc[0] - le);
      end
    end
  endtask

  task automatic test_charge();
    int ivl[$];
    int le;
    int n;
    clear_q();
    n = int'($urandom_range(3, 5));
    for (int i = 0; i < n; i++)         ivl.push_back(jit(1, 3));
    for (int i = 0; i < n; i++)         ivl.push_back(jit(2, 3));
    for (int i = 0; i < n; i++)         ivl.push_back(jit(3, 3));
    for (int i = 0; i < (3 * n) / 2; i++) ivl.push_back(jit(4, 3));
    for (int i = 0; i < n / 2; i++)     ivl.push_back(jit(3, 3));
    for (int i = 0; i < 2 * n; i++)     ivl.push_back(jit(4, 3));
    model_seq(ivl);
    drive(ivl, 1'b1, le);
    checks++;
    if (got_note.size() !== 6) begin errors++; $display("FAIL charge_nvld_count: got %0d exp 6", got_note.size()); end
    foreach (exp_note[i]) if (i < got_note.size()) begin
      checks++;
      if (got_note[i] !== exp_note[i] || got_len[i] !== exp_len[i]) begin
        errors++; $display("FAIL charge_note[%0d]: got %0d/%0d exp %0d/%0d", i, got_note[i], got_len[i], exp_note[i], exp_len[i]);
      end
    end
    checks++;
    if (got_tune.size() !== 1 || (got_tune.size() == 1 && got_tune[0] !== 1)) begin
      errors++; $display("FAIL charge_tune: got %0d pulses exp 1 CHARGE", got_tune.size());
    end
    checks++; if (tune !== 2'd1) begin errors++; $display("FAIL charge_tune_hold: got %0d exp 1", tune); end
    checks++;
    if (note !== 3'd4 || note_len !== 12'(2 * n)) begin
      errors++; $display("FAIL charge_note_hold: got %0d/%0d exp 4/%0d", note, note_len, 2 * n);
    end
  endtask

  task automatic test_batt_low();
    int ivl[$];
    int le;
    int seq[6] = '{4, 3, 4, 3, 2, 1};
    clear_q();
    foreach (seq[s]) begin
      int c;
      c = int'($urandom_range(2, 4));
      for (int i = 0; i < c; i++) ivl.push_back(jit(seq[s], 4));
    end
    model_seq(ivl);
    drive(ivl, 1'b1, le);
    checks++;
    if (got_note.size() !== exp_note.size()) begin errors++; $display("FAIL batt_nvld_count: got %0d exp %0d", got_note.size(), exp_note.size()); end
    foreach (exp_note[i]) if (i < got_note.size()) begin
      checks++;
      if (got_note[i] !== exp_note[i] || got_len[i] !== exp_len[i]) begin
        errors++; $display("FAIL batt_note[%0d]: got %0d/%0d exp %0d/%0d", i, got_note[i], got_len[i], exp_note[i], exp_len[i]);
      end
    end
    checks++;
    if (got_tune.size() !== 1 || (got_tune.size() == 1 && got_tune[0] !== 2)) begin
      errors++; $display("FAIL batt_tune: got %0d pulses exp 1 BATT_LOW", got_tune.size());
    end
  endtask

  task automatic test_too_fast();
    int ivl[$];
    int le;
    int seq[7] = '{1, 2, 3, 1, 2, 3, 1};
    clear_q();
    foreach (seq[s]) for (int i = 0; i < 2; i++) ivl.push_back(jit(seq[s], 5));
    model_seq(ivl);
    drive(ivl, 1'b1, le);
    checks++;
    if (got_tune.size() !== 2) begin errors++; $display("FAIL toofast_count: got %0d exp 2", got_tune.size()); end
    foreach (got_tune[i]) begin
      checks++;
      if (got_tune[i] !== 3) begin errors++; $display("FAIL toofast_tune[%0d]: got %0d exp 3", i, got_tune[i]); end
    end
    checks++;
    if (got_note.size() !== exp_note.size()) begin errors++; $display("FAIL toofast_nvld_count: got %0d exp %0d", got_note.size(), exp_note.size()); end
  endtask

  task automatic test_none_and_bounds();
    int ivl[$] = '{498, 498, 498, 400, 400, 373, 373, 296, 249, 249, 296, 249,
                   467, 529, 466, 530, 1023, 498, 1024, 498, 498};
    int le;
    clear_q();
    model_seq(ivl);
    drive(ivl, 1'b1, le);
    checks++;
    if (got_note.size() !== exp_note.size()) begin errors++; $display("FAIL bounds_nvld_count: got %0d exp %0d", got_note.size(), exp_note.size()); end
    foreach (exp_note[i]) if (i < got_note.size()) begin
      checks++;
      if (got_note[i] !== exp_note[i] || got_len[i] !== exp_len[i]) begin
        errors++; $display("FAIL bounds_note[%0d]: got %0d/%0d exp %0d/%0d", i, got_note[i], got_len[i], exp_note[i], exp_len[i]);
      end
    end
    checks++;
    if (got_tune.size() !== 0) begin errors++; $display("FAIL bounds_no_tune: got %0d pulses exp 0", got_tune.size()); end
  endtask

  task automatic test_random();
    int ivl[$];
    int le;
    clear_q();
    for (int s = 0; s < 10; s++) begin
      int n, c;
      n = int'($urandom_range(0, 4));
      c = int'($urandom_range(1, 3));
      for (int i = 0; i < c; i++) begin
        if (n == 0) ivl.push_back(int'($urandom_range(100, 1100)));
        else        ivl.push_back(jit(n, nom[n - 1] / 16 + 2));
      end
    end
    model_seq(ivl);
    drive(ivl, 1'b1, le);
    checks++;
    if (got_note.size() !== exp_note.size()) begin errors++; $display("FAIL random_nvld_count: got %0d exp %0d", got_note.size(), exp_note.size()); end
    foreach (exp_note[i]) if (i < got_note.size()) begin
      checks++;
      if (got_note[i] !== exp_note[i] || got_len[i] !== exp_len[i]) begin
        errors++; $display("FAIL random_note[%0d]: got %0d/%0d exp %0d/%0d", i, got_note[i], got_len[i], exp_note[i], exp_len[i]);
      end
    end
    checks++;
    if (got_tune.size() !== exp_tune.size()) begin errors++; $display("FAIL random_tune_count: got %0d exp %0d", got_tune.size(), exp_tune.size()); end
    foreach (exp_tune[i]) if (i < got_tune.size()) begin
      checks++;
      if (got_tune[i] !== exp_tune[i]) begin errors++; $display("FAIL random_tune[%0d]: got %0d exp %0d", i, got_tune[i], exp_tune[i]); end
    end
  endtask

  task automatic test_pol_err();
    @(posedge clk); #1 piezo = 1'b0; piezo_n = 1'b0;
    @(posedge clk); #1 piezo_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pol_err !== 1'b0) begin errors++; $display("FAIL pol_err_glitch: got %b exp 0", pol_err); end
    @(posedge clk); #1 piezo = 1'b1; piezo_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 set_p(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pol_err !== 1'b1) begin errors++; $display("FAIL pol_err_set: got %b exp 1", pol_err); end
    repeat (1100) @(posedge clk);
    @(negedge clk);
    checks++; if (pol_err !== 1'b1) begin errors++; $display("FAIL pol_err_sticky: got %b exp 1", pol_err); end
  endtask

  task automatic test_reset_mid_note();
    int ivl[$] = '{498, 498, 498, 498};
    int le;
    clear_q();
    drive(ivl, 1'b0, le);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    set_p(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    hist.delete();
    repeat (1200) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got_note.size() !== 0) begin errors++; $display("FAIL midreset_no_note: got %0d pulses exp 0", got_note.size()); end
    checks++; if (pol_err !== 1'b0) begin errors++; $display("FAIL midreset_pol_err: got %b exp 0", pol_err); end
    checks++; if (note_len !== 12'd0) begin errors++; $display("FAIL midreset_note_len: got %0d exp 0", note_len); end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_charge();
    test_batt_low();
    test_too_fast();
    test_none_and_bounds();
    test_random();
    test_pol_err();
    test_reset_mid_note();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
